out_port_tx: RTL



---
 rtl/out_port_pkg.sv | 6 +
 rtl/sync_fifo.sv | 35 +++
 rtl/out_port_tx.sv | 98 +++++++++
 3 files changed

// File: rtl/out_port_pkg.sv
// out_port_pkg: shared FSM state encoding and line constants for out_port_tx (OUT_PORT_PARITY_EN adds parity)
package out_port_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: wrap-bit pointer FIFO; writes while full are dropped and flagged in a sticky overflow
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
            overflow <= overflow | (wr_en && full);
        end
    end
    always_ff @(posedge clk)
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/out_port_tx.sv
// out_port_tx: queues 16-bit port words and sends each as two 8N1 frames, low byte first (8E1 with OUT_PORT_PARITY_EN)
module out_port_tx
    import out_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        overflow,
    output logic        tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic byte_sel, sel_n, pop, last, tx_d;
    logic [15:0] hold, hold_n, head;
    logic [7:0] byte_n;
    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop),
        .rd_data(head), .full(full), .empty(empty), .overflow(overflow)
    );
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            byte_sel <= 1'b0;
            hold <= '0;
            tx <= IDLE_LEVEL;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_idx_n;
            byte_sel <= sel_n;
            hold <= hold_n;
            tx <= tx_d;
        end
    end
    always_comb begin
        last = cnt == CW'(CLKS_PER_BIT - 1);
        state_n = state;
        cnt_n = last ? '0 : cnt + 1'b1;
        bit_idx_n = bit_idx;
        sel_n = byte_sel;
        hold_n = hold;
        pop = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop = 1'b1;
                    hold_n = head;
                    sel_n = 1'b0;
                    state_n = START;
                end
            end
            START: if (last) begin
                state_n = DATA;
                bit_idx_n = '0;
            end
            DATA: if (last) begin
                if (bit_idx == 3'(DATA_BITS - 1))
`ifdef OUT_PORT_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                else
                    bit_idx_n = bit_idx + 1'b1;
            end
`ifdef OUT_PORT_PARITY_EN
            PARITY: if (last) state_n = STOP;
`endif
            STOP: if (last) begin
                state_n = byte_sel ? IDLE : START;
                sel_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        byte_n = sel_n ? hold_n[15:8] : hold_n[7:0];
        tx_d = state_n == START ? ~IDLE_LEVEL :
               state_n == DATA ? byte_n[bit_idx_n] :
`ifdef OUT_PORT_PARITY_EN
               state_n == PARITY ? ^byte_n :
`endif
               IDLE_LEVEL;
    end
endmodule
